// File: rtl/encode_sync_tx_if.sv
// Bus bundle for the sync-word transmitter: timing-event strobes in,
// serial link and status out.
//
// Handshake: the four event inputs are single-cycle strobes with no ready.
// The transmitter accepts every strobe. A strobe that lands on an
// already-pending request of the same kind is merged into it and counted
// in drop_cnt_o. tx_busy_o reports status only and never back-pressures
// the event source.
interface encode_sync_tx_if #(
  parameter int SERIAL_MODE = 1
);
  logic                   encode_zero_i;
  logic                   scan_start_i;
  logic                   scan_test_i;
  logic                   scan_end_i;
  logic                   tx_busy_o;
  logic [7:0]             drop_cnt_o;
  logic                   SPI_MCLK;
  logic [SERIAL_MODE-1:0] SPI_MOSI;
  logic [1:0]             fsm_state;   // debug view of the serialiser FSM

  // Event source (scan-control logic) plus link observer
  modport master (
    output encode_zero_i, scan_start_i, scan_test_i, scan_end_i,
    input  tx_busy_o, drop_cnt_o, SPI_MCLK, SPI_MOSI, fsm_state
  );

  // Transmitter side
  modport slave (
    input  encode_zero_i, scan_start_i, scan_test_i, scan_end_i,
    output tx_busy_o, drop_cnt_o, SPI_MCLK, SPI_MOSI, fsm_state
  );
endinterface

// File: rtl/encode_sync_tx.sv
// Sync-word link transmitter. Timing events (encode zero, scan begin/test/end)
// are latched as pending requests. Each request is sent as one 16-bit word,
// MSB first, on SPI_MCLK/SPI_MOSI. Frames are separated by an MCLK-idle gap,
// which the receiver uses as its word delimiter.
module encode_sync_tx #(
  parameter int DATA_WIDTH  = 16,
  parameter int SERIAL_MODE = 1,
  parameter int CLK_DIV     = 2,
  parameter int GAP_CYCLES  = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  encode_sync_tx_if.slave  bus
);

  localparam int N  = DATA_WIDTH / SERIAL_MODE;
  localparam int BW = $clog2(N + 1);
  localparam int HW = $clog2(CLK_DIV + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [DATA_WIDTH-1:0] WORD_EZ = DATA_WIDTH'(16'hECDE);
  localparam logic [DATA_WIDTH-1:0] WORD_SS = DATA_WIDTH'(16'h5A51);
  localparam logic [DATA_WIDTH-1:0] WORD_ST = DATA_WIDTH'(16'h5A53);
  localparam logic [DATA_WIDTH-1:0] WORD_SE = DATA_WIDTH'(16'h5A50);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t state;

  // Strobes registered once. This is the first stage of the
  // pulse -> pending -> load pipeline.
  logic req_ez, req_ss, req_st, req_se;

  // Pending requests and their next values
  logic pend_ez, pend_ss, pend_st, pend_se;
  logic pend_ez_n, pend_ss_n, pend_st_n, pend_se_n;

  // Load-time selection
  logic                  load;
  logic                  clr_ez, clr_ss, clr_st, clr_se;
  logic [DATA_WIDTH-1:0] load_word;

  // Merge accounting
  logic       drop_ez, drop_ss, drop_st, drop_se;
  logic [2:0] drop_sum;
  logic [8:0] drop_total;
  logic [7:0] drop_cnt;
  logic [7:0] drop_cnt_n;

  // Serialiser datapath
  logic [DATA_WIDTH-1:0]  shreg;
  logic [DATA_WIDTH-1:0]  shreg_next;
  logic [HW-1:0]          half_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [GW-1:0]          gap_cnt;
  logic                   mclk;
  logic [SERIAL_MODE-1:0] mosi;

  // Pick the highest-priority pending request when the link is free:
  // encode zero > scan end > scan test > scan start.
  always_comb begin
    load      = (state == IDLE) && (pend_ez || pend_ss || pend_st || pend_se);
    clr_ez    = 1'b0;
    clr_ss    = 1'b0;
    clr_st    = 1'b0;
    clr_se    = 1'b0;
    load_word = '0;
    if (load) begin
      if (pend_ez) begin
        clr_ez    = 1'b1;
        load_word = WORD_EZ;
      end else if (pend_se) begin
        clr_se    = 1'b1;
        load_word = WORD_SE;
      end else if (pend_st) begin
        clr_st    = 1'b1;
        load_word = WORD_ST;
      end else begin
        clr_ss    = 1'b1;
        load_word = WORD_SS;
      end
    end
  end

  // Next pending state. A new strobe beats a same-cycle clear. For scan
  // events the last one wins, and scan end wins a same-cycle tie.
  always_comb begin
    pend_ez_n = (pend_ez && !clr_ez) || req_ez;
    pend_ss_n = pend_ss && !clr_ss;
    pend_st_n = pend_st && !clr_st;
    pend_se_n = pend_se && !clr_se;
    if (req_se) begin
      pend_se_n = 1'b1;
      pend_ss_n = 1'b0;
      pend_st_n = 1'b0;
    end else begin
      if (req_ss) pend_ss_n = 1'b1;
      if (req_st) pend_st_n = 1'b1;
      if (req_ss || req_st) pend_se_n = 1'b0;
    end
  end

  // A drop is a strobe landing on a flag that stays set anyway. Start and
  // test strobes cancelled by a simultaneous end are not drops.
  always_comb begin
    drop_ez    = req_ez && pend_ez && !clr_ez;
    drop_se    = req_se && pend_se && !clr_se;
    drop_ss    = req_ss && !req_se && pend_ss && !clr_ss;
    drop_st    = req_st && !req_se && pend_st && !clr_st;
    drop_sum   = 3'(drop_ez) + 3'(drop_se) + 3'(drop_ss) + 3'(drop_st);
    drop_total = {1'b0, drop_cnt} + {6'b0, drop_sum};
    drop_cnt_n = drop_total[8] ? 8'hFF : drop_total[7:0];
  end

  // Request capture, pending flags and the saturating drop counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_ez   <= 1'b0;
      req_ss   <= 1'b0;
      req_st   <= 1'b0;
      req_se   <= 1'b0;
      pend_ez  <= 1'b0;
      pend_ss  <= 1'b0;
      pend_st  <= 1'b0;
      pend_se  <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      req_ez   <= bus.encode_zero_i;
      req_ss   <= bus.scan_start_i;
      req_st   <= bus.scan_test_i;
      req_se   <= bus.scan_end_i;
      pend_ez  <= pend_ez_n;
      pend_ss  <= pend_ss_n;
      pend_st  <= pend_st_n;
      pend_se  <= pend_se_n;
      drop_cnt <= drop_cnt_n;
    end
  end

  assign shreg_next = shreg << SERIAL_MODE;

  // Serialiser FSM. MOSI changes only on falling MCLK toggles, so it is
  // stable for CLK_DIV cycles on each side of every rising edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      shreg    <= '0;
      half_cnt <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      mclk     <= 1'b0;
      mosi     <= '0;
    end else begin
      case (state)
        IDLE: begin
          mclk <= 1'b0;
          if (load) begin
            state    <= SHIFT;
            shreg    <= load_word;
            mosi     <= load_word[DATA_WIDTH-1 -: SERIAL_MODE];
            half_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        SHIFT: begin
          if (half_cnt == HW'(CLK_DIV - 1)) begin
            half_cnt <= '0;
            if (!mclk) begin
              mclk <= 1'b1;
            end else begin
              mclk <= 1'b0;
              if (bit_cnt == BW'(N - 1)) begin
                mosi    <= '0;
                gap_cnt <= '0;
                state   <= GAP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= shreg_next;
                mosi    <= shreg_next[DATA_WIDTH-1 -: SERIAL_MODE];
              end
            end
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        GAP: begin
          mclk <= 1'b0;
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          mclk  <= 1'b0;
          mosi  <= '0;
        end
      endcase
    end
  end

  assign bus.SPI_MCLK   = mclk;
  assign bus.SPI_MOSI   = mosi;
  assign bus.tx_busy_o  = (state != IDLE);
  assign bus.drop_cnt_o = drop_cnt;
  assign bus.fsm_state  = state;

endmodule
